// File: rtl/axi_req_encoder.sv
// AXI slave front end that serialises AR and AW/W traffic into one packed request stream
// toward an arbiter, with round-robin selection and a per-burst B response.
module axi_req_encoder #(
   parameter logic RD_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_awvalid,
   output logic         s_awready,
   input  logic [31:0]  s_awaddr,
   input  logic [3:0]   s_awid,
   input  logic [7:0]   s_awlen,
   input  logic [2:0]   s_awsize,
   input  logic [1:0]   s_awburst,
   input  logic         s_wvalid,
   output logic         s_wready,
   input  logic [63:0]  s_wdata,
   input  logic [7:0]   s_wstrb,
   input  logic         s_wlast,
   output logic         s_bvalid,
   input  logic         s_bready,
   output logic [3:0]   s_bid,
   output logic [1:0]   s_bresp,
   input  logic         s_arvalid,
   output logic         s_arready,
   input  logic [31:0]  s_araddr,
   input  logic [3:0]   s_arid,
   input  logic [7:0]   s_arlen,
   input  logic [2:0]   s_arsize,
   input  logic [1:0]   s_arburst,
   output logic         req_valid,
   input  logic         req_ready,
   output logic [127:0] result_arb,
   output logic         read_or_write
);

   typedef enum logic [1:0] {IDLE, RD, WR, BRESP} state_t;

   state_t         r_state;
   logic           r_rr_rd;
   logic           r_rd_valid;
   logic           r_bvalid;
   logic [1:0]     r_bresp;
   logic [127:0]   r_result;
   logic [31:0]    r_addr;
   logic [3:0]     r_id;
   logic [7:0]     r_len;
   logic [2:0]     r_size;
   logic [1:0]     r_burst;
   logic [8:0]     r_cnt;

   logic           w_idle;
   logic           w_sel_rd;
   logic           w_sel_wr;
   logic           w_ar_hs;
   logic           w_aw_hs;
   logic           w_w_hs;
   logic           w_last_beat;
   logic [31:0]    w_off;
   logic [31:0]    w_wrap_mask;
   logic [31:0]    w_beat_addr;

   // r_rr_rd set means read wins the next simultaneous AR/AW
   assign w_idle    = (r_state == IDLE) && !rst;
   assign w_sel_rd  = s_arvalid && (!s_awvalid || r_rr_rd);
   assign w_sel_wr  = s_awvalid && (!s_arvalid || !r_rr_rd);
   assign s_arready = w_idle && w_sel_rd;
   assign s_awready = w_idle && w_sel_wr;
   assign w_ar_hs   = s_arvalid && s_arready;
   assign w_aw_hs   = s_awvalid && s_awready;

   assign w_w_hs      = (r_state == WR) && s_wvalid && req_ready;
   assign w_last_beat = (r_cnt == {1'b0, r_len});

   assign w_off       = {23'd0, r_cnt} << r_size;
   assign w_wrap_mask = (({24'd0, r_len} + 32'd1) << r_size) - 32'd1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_beat_addr = r_addr + w_off;
      case (r_burst)
         2'b00:   w_beat_addr = r_addr;
         2'b10:   w_beat_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_off) & w_wrap_mask);
         default: w_beat_addr = r_addr + w_off;
      endcase
   end

   // Write beats pass straight through; reads present the word captured at AR time
   assign req_valid     = r_rd_valid || ((r_state == WR) && s_wvalid);
   assign s_wready      = (r_state == WR) && req_ready;
   assign read_or_write = (r_state == WR);
   assign result_arb    = (r_state == WR)
                        ? {7'd0, s_wdata, s_wstrb, r_len, r_size, r_burst, r_id, w_beat_addr}
                        : r_result;
   assign s_bvalid      = r_bvalid;
   assign s_bid         = r_id;
   assign s_bresp       = r_bresp;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rr_rd    <= RD_FIRST;
         r_rd_valid <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= 2'b00;
         r_result   <= '0;
         r_addr     <= '0;
         r_id       <= '0;
         r_len      <= '0;
         r_size     <= '0;
         r_burst    <= '0;
         r_cnt      <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_ar_hs) begin
                  r_result   <= {7'd0, 64'd0, 8'd0, s_arlen, s_arsize, s_arburst, s_arid, s_araddr};
                  r_rr_rd    <= 1'b0;
                  r_rd_valid <= 1'b1;
                  r_state    <= RD;
               end else if (w_aw_hs) begin
                  r_addr  <= s_awaddr;
                  r_id    <= s_awid;
                  r_len   <= s_awlen;
                  r_size  <= s_awsize;
                  r_burst <= s_awburst;
                  r_cnt   <= '0;
                  r_rr_rd <= 1'b1;
                  r_state <= WR;
               end
            end
            RD: begin
               if (req_ready) begin
                  r_rd_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            WR: begin
               if (w_w_hs) begin
                  r_cnt <= r_cnt + 9'd1;
                  // A wlast that disagrees with the beat count is a protocol error
                  if (w_last_beat || s_wlast) begin
                     r_bresp  <= (s_wlast != w_last_beat) ? 2'b10 : 2'b00;
                     r_bvalid <= 1'b1;
                     r_state  <= BRESP;
                  end
               end
            end
            BRESP: begin
               if (s_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/axi_req_encoder.md
AXI_REQ_ENCODER -- requirements
Module: axi_req_encoder

Interface
REQ-001 SHALL have parameter RD_FIRST, default 1'b0, which selects the side preferred on the first simultaneous AW/AR after reset (1 = read).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- s_awvalid/s_awready  in/out  1/1  AW handshake
- s_awaddr, s_awid, s_awlen, s_awsize, s_awburst  in  32,4,8,3,2  AW fields
- s_wvalid/s_wready  in/out  1/1  W handshake
- s_wdata, s_wstrb, s_wlast  in  64,8,1  W fields
- s_bvalid/s_bready  out/in  1/1  B handshake
- s_bid, s_bresp  out  4,2  B fields
- s_arvalid/s_arready  in/out  1/1  AR handshake
- s_araddr, s_arid, s_arlen, s_arsize, s_arburst  in  32,4,8,3,2  AR fields
- req_valid/req_ready  out/in  1/1  packed-request handshake toward the arbiter
- result_arb  out  128  packed request word
- read_or_write  out  1  0 = READ, 1 = WRITE; valid while req_valid=1

Function
REQ-003 SHALL pack result_arb as [31:0] addr, [35:32] id, [37:36] burst, [40:38] size, [48:41] len, [56:49] wstrb, [120:57] wdata, [127:121] = 0.
REQ-004 SHALL implement the FSM states IDLE, RD, WR and BRESP.
REQ-005 In IDLE, SHALL select the requester as follows:
- Only arvalid asserted: select read.
- Only awvalid asserted: select write.
- Both asserted: select the side not served last (round-robin flag).
REQ-006 In IDLE, SHALL assert exactly one of s_arready/s_awready, combinationally, for the selected side; on that handshake it SHALL capture the channel fields and move to RD or WR; both readies SHALL be 0 in every other state.
REQ-007 In RD:
- SHALL hold req_valid=1 and read_or_write=0.
- SHALL drive the captured AR fields, with wstrb=0 and wdata=0.
- On req_ready=1, SHALL return to IDLE.
- Latency: arready in cycle N, req_valid from cycle N+1.
REQ-008 In WR:
- req_valid SHALL equal s_wvalid, and s_wready SHALL equal req_ready (combinational pass-through).
- read_or_write SHALL be 1.
- The word SHALL carry the captured id/burst/size/len, the current beat's wdata/wstrb, and the beat address.
REQ-009 Beat address for beat n (n = 0..len) SHALL be:
- FIXED (2'b00): awaddr.
- INCR (2'b01): awaddr + (n << size), modulo 2^32.
- WRAP (2'b10): awaddr advanced by n<<size, wrapping within the aligned window of (len+1)<<size bytes.
- Reserved (2'b11): treated as INCR.
REQ-010 SHALL use a 9-bit beat counter, cleared on AW capture and incremented on each W/req handshake.
REQ-011 The burst SHALL end on the handshake of beat n==len or of a beat with wlast=1, whichever comes first, and the FSM SHALL then go to BRESP.
REQ-012 s_bresp SHALL be 2'b10 (SLVERR) if wlast was asserted on beat n<len or was deasserted on beat n==len; otherwise it SHALL be 2'b00.
REQ-013 In BRESP, SHALL hold s_bvalid=1 with s_bid set to the captured awid, then return to IDLE on s_bready=1.
REQ-014 The round-robin flag SHALL update on each AW or AR capture to mark that side as served last.
REQ-015 s_arvalid or s_awvalid arriving during RD/WR/BRESP SHALL wait; the block SHALL not reorder or drop any request.
REQ-016 Outputs SHALL remain stable while req_valid=1 and req_ready=0.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL reset as follows:
- State SHALL become IDLE.
- req_valid, s_bvalid, s_awready (registered part), s_arready and s_wready SHALL be 0.
- result_arb, s_bid, s_bresp, beat counter and captured fields SHALL be 0.
- The round-robin flag SHALL equal RD_FIRST.
REQ-018 A reset mid-burst SHALL abandon the burst, issue no B response, and accept a new request from the first post-reset cycle.

Verification
REQ-019 Single read: araddr=0x1000_0040, arid=3, arlen=0, arsize=3, arburst=1 -> the bench SHALL check req_valid one cycle after arready, with result_arb[31:0]=0x1000_0040, [35:32]=3, [56:49]=0 and read_or_write=0.
REQ-020 INCR write burst: awaddr=0x100, len=3, size=3, 4 beats with wlast on beat 3 -> the bench SHALL check beat addresses 0x100, 0x108, 0x110, 0x118, then bvalid with bresp=0 and bid=awid.
REQ-021 WRAP write burst: awaddr=0x118, len=3, size=3 -> the bench SHALL check beat addresses 0x118, 0x100, 0x108, 0x110.
REQ-022 Early wlast on beat 1 of a len=3 burst -> the bench SHALL check that the burst ends after 2 beats with bresp=2'b10.
REQ-023 Simultaneous arvalid and awvalid with RD_FIRST=0, repeated twice -> the bench SHALL check the order write, read, write, read; and with req_ready held 0 for 5 cycles, the bench SHALL check that result_arb remains stable.
REQ-024 rst asserted during beat 2 of a len=7 burst -> the bench SHALL check that the next cycle is IDLE, that no bvalid is issued, and that a following read is served normally.
